// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a carry
// register, one bit per clock, LSB first. The sum for a WIDTH-bit operand
// appears WIDTH cycles after acceptance, together with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port, which
// selects a - b (computed as a + ~b + 1; cout=1 means no borrow).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             last_bit;
   logic             fa_s, fa_c;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   // Operand conditioning at acceptance: subtraction folds into the add path.
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         b_in = ~b;
         c_in = 1'b1;
      end else begin
         b_in = b;
         c_in = cin;
      end
`else
      b_in = b;
      c_in = cin;
`endif
   end

   // Single full-adder cell working on the LSBs of the shifting operands.
   always_comb begin
      fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
      fa_c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      accept   = start && (state_q != RUN);
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: start is honoured in IDLE and DONE, ignored in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: status decoded straight from state, results from registers.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      sum  = sum_q;
      cout = cout_q;
   end

   // Datapath next values: latch on accept, shift one bit per RUN cycle,
   // publish the result only on the edge that processes the final bit.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (accept) begin
         a_d     = a;
         b_d     = b_in;
         carry_d = c_in;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         carry_d = fa_c;
         cnt_d   = cnt_q + CW'(1);
         res_d   = {fa_s, res_q[WIDTH-1:1]};
         if (last_bit) begin
            sum_d  = {fa_s, res_q[WIDTH-1:1]};
            cout_d = fa_c;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: a WIDTH=8 instance for directed/random traffic
// and a WIDTH=2 instance for an exhaustive sweep. Expected results and their
// done cycles are queued at stimulus time and popped when done is observed.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub8;
`endif
   logic       start2, cin2, busy2, done2, cout2;
   logic [1:0] a2, b2, sum2;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub8),
`endif
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

   typedef struct {
      logic [8:0] res;
      int         due;
   } exp_t;

   exp_t q8[$];
   exp_t q2[$];
   exp_t e8, e2;
   logic [8:0] last8 = '0;
   logic [2:0] last2 = '0;
   int busy_run8 = 0;
   int busy_run2 = 0;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // WIDTH=8 monitor: result, latency, busy length and result hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run8 = 0;
         last8     = '0;
      end else begin
         if (busy8) begin
            busy_run8++;
            check_eq("hold8", {cout8, sum8}, last8);
         end
         if (done8) begin
            if (q8.size() == 0) check_eq("spurious_done8", done8, 0);
            else begin
               e8 = q8.pop_front();
               check_eq("result8", {cout8, sum8}, e8.res);
               check_eq("done_cycle8", cyc, e8.due);
               check_eq("busy_len8", busy_run8, 8);
               last8 = e8.res;
            end
            busy_run8 = 0;
         end
      end
   end

   // WIDTH=2 monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run2 = 0;
         last2     = '0;
      end else begin
         if (busy2) begin
            busy_run2++;
            check_eq("hold2", {cout2, sum2}, last2);
         end
         if (done2) begin
            if (q2.size() == 0) check_eq("spurious_done2", done2, 0);
            else begin
               e2 = q2.pop_front();
               check_eq("result2", {cout2, sum2}, e2.res);
               check_eq("done_cycle2", cyc, e2.due);
               check_eq("busy_len2", busy_run2, 2);
               last2 = e2.res;
            end
            busy_run2 = 0;
         end
      end
   end

   // Called at a negedge: drive a start for one cycle and queue the expectation.
   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
      exp_t x;
      if (s) x.res = {1'b0, a} + {1'b0, ~b} + 9'd1;
      else   x.res = {1'b0, a} + {1'b0, b} + {8'd0, c};
      x.due  = cyc + 9;
      q8.push_back(x);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = s;
`endif
      @(negedge clk);
      start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = $urandom;
   endtask

   task automatic go2(input logic [1:0] a, input logic [1:0] b, input logic c);
      exp_t x;
      x.res = {1'b0, a} + {1'b0, b} + {2'd0, c};
      x.due = cyc + 3;
      q2.push_back(x);
      start2 = 1'b1; a2 = a; b2 = b; cin2 = c;
      @(negedge clk);
      start2 = 1'b0; a2 = $urandom; b2 = $urandom; cin2 = $urandom;
   endtask

   task automatic wait8(input int bound);
      int k = 0;
      while (q8.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check_eq("timeout8", q8.size(), 0);
   endtask

   task automatic wait2(input int bound);
      int k = 0;
      while (q2.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check_eq("timeout2", q2.size(), 0);
   endtask

   task automatic wait_done8(input int bound);
      int k = 0;
      while (!done8 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check_eq("wait_done8", done8, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = 1'b0;
`endif
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_sum", sum8, 0);
      check_eq("rst_cout", cout8, 0);
      check_eq("rst_busy", busy8, 0);
      check_eq("rst_done", done8, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add with latency check.
      go8(8'h3C, 8'h0F, 1'b0, 1'b0);
      wait8(30);

      // Carry out, then back-to-back start issued in the done cycle.
      go8(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_done8(30);
      go8(8'hFF, 8'hFF, 1'b1, 1'b0);
      wait8(30);

      // Start during RUN must be ignored.
      go8(8'h01, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      @(negedge clk);
      start8 = 1'b0;
      wait8(30);
      repeat (3) @(negedge clk);
      check_eq("ignored_start_idle", busy8, 0);

      // Asynchronous reset mid-RUN aborts with no done pulse.
      go8(8'h80, 8'h80, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_sum", sum8, 0);
      check_eq("abort_cout", cout8, 0);
      check_eq("abort_busy", busy8, 0);
      check_eq("abort_done", done8, 0);
      q8.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      go8(8'h12, 8'h34, 1'b0, 1'b0);
      wait8(30);

`ifdef SERIAL_ADDER_SUB_EN
      go8(8'h10, 8'h01, 1'b1, 1'b1);
      wait8(30);
      go8(8'h01, 8'h02, 1'b0, 1'b1);
      wait8(30);
`endif

      // Random traffic with random gaps, including back-to-back starts.
      for (int i = 0; i < 25; i++) begin
         int gap;
         logic s;
         gap = $urandom_range(0, 3);
`ifdef SERIAL_ADDER_SUB_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         if (gap == 0 && q8.size() != 0) wait_done8(30);
         else begin
            wait8(30);
            repeat (gap) @(negedge clk);
         end
         go8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s);
      end
      wait8(30);

      // Exhaustive sweep at WIDTH=2.
      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         v = 5'(i);
         go2(v[1:0], v[3:2], v[4]);
         wait2(10);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
